fc_l2_port_arbiter: RTL and testbench

// - Shares one fabric-controller L2 TCDM master port between two requesters: port 0 is the FC core data bus and port 1 is an auxiliary master (debug/loader).
// - Round-robin arbitration with a request lock: a request presented but not yet granted keeps ownership of the L2 port.
// - An in-order routing FIFO steers each r_valid/r_rdata/r_opc back to the requester that issued the transaction.
// - Sits between the core/aux buses and the L2 data master port.

---
 rtl/fc_l2_port_arbiter.sv | 98 +++++++++
 tb/tb_fc_l2_port_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fc_l2_port_arbiter.sv
// fc_l2_port_arbiter: round-robin arbiter with request lock sharing one L2 TCDM port
// between the FC core (port 0) and an aux master (port 1), with in-order response routing.
module fc_l2_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               s0_req_i,
    input  logic [ADDR_WIDTH-1:0]              s0_add_i,
    input  logic                               s0_wen_i,
    input  logic [DATA_WIDTH-1:0]              s0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]            s0_be_i,
    output logic                               s0_gnt_o,
    output logic                               s0_r_valid_o,
    output logic [DATA_WIDTH-1:0]              s0_r_rdata_o,
    output logic                               s0_r_opc_o,
    input  logic                               s1_req_i,
    input  logic [ADDR_WIDTH-1:0]              s1_add_i,
    input  logic                               s1_wen_i,
    input  logic [DATA_WIDTH-1:0]              s1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]            s1_be_i,
    output logic                               s1_gnt_o,
    output logic                               s1_r_valid_o,
    output logic [DATA_WIDTH-1:0]              s1_r_rdata_o,
    output logic                               s1_r_opc_o,
    output logic                               m_req_o,
    output logic [ADDR_WIDTH-1:0]              m_add_o,
    output logic                               m_wen_o,
    output logic [DATA_WIDTH-1:0]              m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]            m_be_o,
    input  logic                               m_gnt_i,
    input  logic                               m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]              m_r_rdata_i,
    input  logic                               m_r_opc_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               rsp_err_o
);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;

    logic [1:0]                 req;
    logic                       lock, lock_port, rr_ptr, sel, req_sel, full, hs, pop, head;
    logic [MAX_OUTSTANDING-1:0] route;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              count;

    assign req     = {s1_req_i, s0_req_i};
    assign full    = count == CW'(MAX_OUTSTANDING);
    assign sel     = lock ? lock_port : (&req ? rr_ptr : req[1]);
    assign req_sel = req[sel];
    assign m_req_o = req_sel & ~full;
    assign hs      = m_req_o & m_gnt_i;
    assign pop     = m_r_valid_i & (count != '0);
    assign head    = route[rd_ptr];

    // Idle bus presents a harmless read with no byte lanes enabled
    assign m_add_o   = !req_sel ? '0   : (sel ? s1_add_i   : s0_add_i);
    assign m_wen_o   = !req_sel ? 1'b1 : (sel ? s1_wen_i   : s0_wen_i);
    assign m_wdata_o = !req_sel ? '0   : (sel ? s1_wdata_i : s0_wdata_i);
    assign m_be_o    = !req_sel ? '0   : (sel ? s1_be_i    : s0_be_i);

    assign s0_gnt_o      = hs & ~sel;
    assign s1_gnt_o      = hs & sel;
    assign s0_r_valid_o  = pop & ~head;
    assign s1_r_valid_o  = pop & head;
    assign s0_r_rdata_o  = m_r_rdata_i;
    assign s1_r_rdata_o  = m_r_rdata_i;
    assign s0_r_opc_o    = m_r_opc_i;
    assign s1_r_opc_o    = m_r_opc_i;
    assign outstanding_o = count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            route     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            lock      <= 1'b0;
            lock_port <= 1'b0;
            rr_ptr    <= 1'b0;
            rsp_err_o <= 1'b0;
        end else begin
            if (hs) begin
                route[wr_ptr] <= sel;
                wr_ptr        <= wr_ptr + 1'b1;
                rr_ptr        <= ~sel;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(hs) - CW'(pop);
            // An ungranted request holds the port until its handshake
            lock <= m_req_o & ~m_gnt_i;
            if (m_req_o & ~m_gnt_i) lock_port <= sel;
            if (m_r_valid_i && count == '0) rsp_err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// tb_fc_l2_port_arbiter: directed vector table, async reset check and randomized
// traffic against a queue-based reference model of the arbiter.
module tb_fc_l2_port_arbiter;
    localparam logic [31:0] A0 = 32'h1C000100;
    localparam logic [31:0] A1 = 32'h1C000200;

    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        r0 = 0, r1 = 0, wen0 = 1, wen1 = 1, mg = 0, mrv = 0, mopc = 0;
    logic [31:0] a0 = 0, a1 = 0, wd0 = 0, wd1 = 0, mrd = 0;
    logic [3:0]  be0 = 0, be1 = 0;
    logic        g0, g1, rv0, rv1, op0, op1, mreq, mwen, err;
    logic [31:0] rd0, rd1, madd, mwd;
    logic [3:0]  mbe;
    logic [2:0]  outs;

    int nvec = 0, nmis = 0;

    fc_l2_port_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .s0_req_i(r0), .s0_add_i(a0), .s0_wen_i(wen0), .s0_wdata_i(wd0), .s0_be_i(be0),
        .s0_gnt_o(g0), .s0_r_valid_o(rv0), .s0_r_rdata_o(rd0), .s0_r_opc_o(op0),
        .s1_req_i(r1), .s1_add_i(a1), .s1_wen_i(wen1), .s1_wdata_i(wd1), .s1_be_i(be1),
        .s1_gnt_o(g1), .s1_r_valid_o(rv1), .s1_r_rdata_o(rd1), .s1_r_opc_o(op1),
        .m_req_o(mreq), .m_add_o(madd), .m_wen_o(mwen), .m_wdata_o(mwd), .m_be_o(mbe),
        .m_gnt_i(mg), .m_r_valid_i(mrv), .m_r_rdata_i(mrd), .m_r_opc_i(mopc),
        .outstanding_o(outs), .rsp_err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  in;
        logic [31:0] d;
        logic [5:0]  ex;
        logic [2:0]  o;
        logic        e;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // in = {r0,r1,gnt,rvalid}; ex = {m_req,sel,gnt0,gnt1,rv0,rv1}
    task automatic add_vec(input logic [3:0] in, input logic [31:0] d, input logic [5:0] ex,
                           input logic [2:0] o, input logic e);
        vec_t v;
        v.in = in; v.d = d; v.ex = ex; v.o = o; v.e = e;
        tbl.push_back(v);
    endtask

    int  q[$];
    int  owner, rr, sel;
    bit  pend[2], pw[2], ereq, hs, errm, erv0, erv1;
    logic [31:0] pa[2], pd[2];
    logic [3:0]  pb[2];

    initial begin
        add_vec(4'b1010, 32'h0,        6'b101000, 3'd0, 1'b0);
        add_vec(4'b0001, 32'hDEADBEEF, 6'b000010, 3'd1, 1'b0);
        add_vec(4'b1110, 32'h0,        6'b110100, 3'd0, 1'b0);
        add_vec(4'b1111, 32'h11111111, 6'b101001, 3'd1, 1'b0);
        add_vec(4'b1111, 32'h22222222, 6'b110110, 3'd1, 1'b0);
        add_vec(4'b0001, 32'h33333333, 6'b000001, 3'd1, 1'b0);
        add_vec(4'b0100, 32'h0,        6'b110000, 3'd0, 1'b0);
        add_vec(4'b1100, 32'h0,        6'b110000, 3'd0, 1'b0);
        add_vec(4'b1110, 32'h0,        6'b110100, 3'd0, 1'b0);
        add_vec(4'b1110, 32'h0,        6'b101000, 3'd1, 1'b0);
        add_vec(4'b1110, 32'h0,        6'b110100, 3'd2, 1'b0);
        add_vec(4'b1110, 32'h0,        6'b101000, 3'd3, 1'b0);
        add_vec(4'b1110, 32'h0,        6'b000000, 3'd4, 1'b0);
        add_vec(4'b1111, 32'h44444444, 6'b000001, 3'd4, 1'b0);
        add_vec(4'b1110, 32'h0,        6'b110100, 3'd3, 1'b0);
        add_vec(4'b0001, 32'h55555555, 6'b000010, 3'd4, 1'b0);
        add_vec(4'b0001, 32'h66666666, 6'b000001, 3'd3, 1'b0);
        add_vec(4'b0001, 32'h77777777, 6'b000010, 3'd2, 1'b0);
        add_vec(4'b0001, 32'h88888888, 6'b000001, 3'd1, 1'b0);
        add_vec(4'b0001, 32'h99999999, 6'b000000, 3'd0, 1'b0);
        add_vec(4'b0000, 32'h0,        6'b000000, 3'd0, 1'b1);

        @(negedge clk);
        chk("rst_m_req", mreq, 0); chk("rst_m_wen", mwen, 1); chk("rst_m_be", mbe, 0);
        chk("rst_m_add", madd, 0); chk("rst_out", outs, 0); chk("rst_err", err, 0);
        chk("rst_gnt", {g0, g1}, 0); chk("rst_rv", {rv0, rv1}, 0);
        rst_ni = 1'b1;
        a0 = A0; a1 = A1; be0 = 4'hF; be1 = 4'hF;

        foreach (tbl[i]) begin
            @(negedge clk);
            {r0, r1, mg, mrv} = tbl[i].in;
            mrd = tbl[i].d;
            #1;
            chk($sformatf("v%0d_m_req", i), mreq, tbl[i].ex[5]);
            chk($sformatf("v%0d_gnt0", i), g0, tbl[i].ex[3]);
            chk($sformatf("v%0d_gnt1", i), g1, tbl[i].ex[2]);
            chk($sformatf("v%0d_rv0", i), rv0, tbl[i].ex[1]);
            chk($sformatf("v%0d_rv1", i), rv1, tbl[i].ex[0]);
            chk($sformatf("v%0d_out", i), outs, tbl[i].o);
            chk($sformatf("v%0d_err", i), err, tbl[i].e);
            if (tbl[i].ex[5]) chk($sformatf("v%0d_m_add", i), madd, tbl[i].ex[4] ? A1 : A0);
            if (!r0 && !r1) begin
                chk($sformatf("v%0d_idle_add", i), madd, 0);
                chk($sformatf("v%0d_idle_wen", i), mwen, 1);
                chk($sformatf("v%0d_idle_be", i), mbe, 0);
            end
            if (mrv) begin
                chk($sformatf("v%0d_rdata0", i), rd0, tbl[i].d);
                chk($sformatf("v%0d_rdata1", i), rd1, tbl[i].d);
            end
        end

        @(negedge clk); r0 = 1; r1 = 0; mg = 1; mrv = 0;
        @(negedge clk);
        @(negedge clk); r0 = 0; mg = 0;
        #1;
        chk("pre_rst_out", outs, 2); chk("pre_rst_err", err, 1);
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_out", outs, 0); chk("arst_err", err, 0); chk("arst_m_req", mreq, 0);
        chk("arst_m_add", madd, 0); chk("arst_m_wen", mwen, 1); chk("arst_m_be", mbe, 0);
        chk("arst_gnt", {g0, g1}, 0); chk("arst_rv", {rv0, rv1}, 0);
        @(negedge clk); rst_ni = 1'b1;

        owner = -1; rr = 0; errm = 0; pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(1, 0) == 1) begin
                    pend[p] = 1; pa[p] = $urandom; pw[p] = 1'($urandom);
                    pd[p] = $urandom; pb[p] = 4'($urandom);
                end
            r0 = pend[0]; a0 = pa[0]; wen0 = pw[0]; wd0 = pd[0]; be0 = pb[0];
            r1 = pend[1]; a1 = pa[1]; wen1 = pw[1]; wd1 = pd[1]; be1 = pb[1];
            sel  = owner >= 0 ? owner : (pend[0] && pend[1]) ? rr : (pend[1] ? 1 : 0);
            ereq = pend[sel] && q.size() < 4;
            mg   = $urandom_range(3, 0) != 0;
            mrv  = q.size() > 0 ? $urandom_range(2, 0) == 0 : $urandom_range(49, 0) == 0;
            mrd  = $urandom; mopc = 1'($urandom);
            hs   = ereq && mg;
            erv0 = mrv && q.size() > 0 && q[0] == 0;
            erv1 = mrv && q.size() > 0 && q[0] == 1;
            #1;
            chk("r_m_req", mreq, ereq);
            chk("r_gnt0", g0, hs && sel == 0);
            chk("r_gnt1", g1, hs && sel == 1);
            if (ereq) begin
                chk("r_m_add", madd, pa[sel]); chk("r_m_wen", mwen, pw[sel]);
                chk("r_m_wdata", mwd, pd[sel]); chk("r_m_be", mbe, pb[sel]);
            end
            chk("r_rv0", rv0, erv0); chk("r_rv1", rv1, erv1);
            chk("r_rdata", {rd0 ^ mrd, rd1 ^ mrd}, 0);
            chk("r_opc", {op0, op1}, {mopc, mopc});
            chk("r_out", outs, q.size());
            chk("r_err", err, errm);
            @(posedge clk);
            if (mrv) begin
                if (q.size() > 0) void'(q.pop_front());
                else errm = 1;
            end
            if (hs) begin
                q.push_back(sel); rr = 1 - sel; owner = -1; pend[sel] = 0;
            end else if (ereq) owner = sel;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
